// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the bounce generator: FSM encoding and LFSR constants.
// The LFSR step/seed helpers live here so the generator and its PRNG agree on them.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    localparam logic [15:0] LFSR_POLY  = 16'hB400;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end
        return nxt;
    endfunction

    // An all-zero seed would lock the LFSR, so it falls back to the reset value.
    function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
        return (s == 16'd0) ? LFSR_RESET : s;
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit free-running Galois LFSR with a synchronous seed load.
module lfsr16
    import bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_RESET;
        end else if (load) begin
            q <= lfsr_seed(seed);
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/bounce_gen.sv
// Mechanical push-button emulator: each request toggles sig to the target level
// through a random odd number of edges with random spacing, then holds it to settle.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned MIN_GAP       = 50_000,
    parameter logic [17:0] GAP_MASK      = 18'h3FFFF,
    parameter logic [3:0]  BOUNCE_MASK   = 4'hF,
    parameter int unsigned SETTLE_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        target,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        sig,
    output logic        ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned GAP_MAX  = MIN_GAP + 32'(GAP_MASK);
    localparam int          GAP_W    = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
    localparam int          SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int          REM_W    = 5;

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_ONE     = GAP_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [REM_W-1:0]    REM_ONE     = REM_W'(1);

    state_t              state, state_nxt;
    logic                sig_nxt;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    logic [REM_W-1:0]    remaining, rem_nxt;
    logic [15:0]         lfsr_q;
    logic                lfsr_load;
    logic [3:0]          n_pairs;

    // Gap length is computed at full width, so MIN_GAP + mask never wraps.
    function automatic logic [GAP_W-1:0] gap_from(input logic [15:0] r);
        logic [31:0] sum;
        sum = MIN_GAP + ({20'd0, r[15:4]} & 32'(GAP_MASK));
        return GAP_W'(sum);
    endfunction

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .q     (lfsr_q)
    );

    assign n_pairs = lfsr_q[3:0] & BOUNCE_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sig        <= INIT_LEVEL;
            gap_cnt    <= '0;
            settle_cnt <= '0;
            remaining  <= '0;
        end else begin
            state      <= state_nxt;
            sig        <= sig_nxt;
            gap_cnt    <= gap_nxt;
            settle_cnt <= settle_nxt;
            remaining  <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sig_nxt    = sig;
        gap_nxt    = gap_cnt;
        settle_nxt = settle_cnt;
        rem_nxt    = remaining;
        lfsr_load  = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                ready     = 1'b1;
                lfsr_load = seed_load;
                if (start) begin
                    if (target == sig) begin
                        state_nxt = DONE;
                    end else begin
                        // First edge lands on the request edge itself.
                        sig_nxt = ~sig;
                        rem_nxt = {n_pairs, 1'b0};
                        gap_nxt = gap_from(lfsr_q);
                        if (n_pairs != 4'd0) begin
                            state_nxt = GAP;
                        end else begin
                            state_nxt  = SETTLE;
                            settle_nxt = SETTLE_LOAD;
                        end
                    end
                end
            end

            GAP: begin
                busy = 1'b1;
                if (gap_cnt == '0) begin
                    sig_nxt = ~sig;
                    rem_nxt = remaining - REM_ONE;
                    gap_nxt = gap_from(lfsr_q);
                    if (remaining == REM_ONE) begin
                        state_nxt  = SETTLE;
                        settle_nxt = SETTLE_LOAD;
                    end
                end else begin
                    gap_nxt = gap_cnt - GAP_ONE;
                end
            end

            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    settle_nxt = settle_cnt - SETTLE_ONE;
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Randomized scoreboard bench for bounce_gen with shortened timing parameters.
module tb_bounce_gen;

    localparam int MG = 4;
    localparam int GM = 3;
    localparam int BM = 3;
    localparam int SC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        target = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'd0;
    logic        sig, ready, busy, done;

    bounce_gen #(
        .INIT_LEVEL    (1'b0),
        .MIN_GAP       (MG),
        .GAP_MASK      (18'd3),
        .BOUNCE_MASK   (4'd3),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .target    (target),
        .seed_load (seed_load),
        .seed      (seed),
        .sig       (sig),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    int exp_done_q[$];
    bit exp_tgt_q[$];
    int exp_edges_q[$];
    int exp_sp_q[$];
    int edge_t[$];

    logic prev_sig = 1'b0;
    bit   prev_done = 1'b0;
    bit   cur_sig = 1'b0;

    int ed, en, sp, act;
    bit et;

    task automatic chk(input bit ok, input string name, input int got, input int want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference PRNG: one step of polynomial division by x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int bounces(input logic [15:0] s);
        return int'(s[3:0]) & BM;
    endfunction

    // Monitor: logs sig edges and judges each finished transaction at its done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            edge_t.delete();
            prev_sig  = sig;
            prev_done = 1'b0;
        end else begin
            chk($onehot({ready, busy, done}), "status_onehot", int'({ready, busy, done}), 0);
            if (sig !== prev_sig) edge_t.push_back(cyc);
            prev_sig = sig;
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    ed = exp_done_q.pop_front();
                    et = exp_tgt_q.pop_front();
                    en = exp_edges_q.pop_front();
                    chk(cyc == ed, "done_cycle", cyc, ed);
                    chk(edge_t.size() == en, "edge_count", edge_t.size(), en);
                    chk(sig === et, "final_sig", int'(sig), int'(et));
                    chk(!prev_done, "done_width", 2, 1);
                    if (en > 0) begin
                        chk((edge_t.size() % 2 == 1) && (edge_t.size() <= 2 * BM + 1),
                            "edge_odd_max", edge_t.size(), en);
                        for (int i = 1; i < en; i++) begin
                            sp = exp_sp_q.pop_front();
                            if (i < edge_t.size()) begin
                                act = edge_t[i] - edge_t[i-1];
                                chk(act == sp && act >= MG + 1 && act <= MG + GM + 1,
                                    "edge_spacing", act, sp);
                            end
                        end
                        if (edge_t.size() > 0)
                            chk(cyc - edge_t[$] == SC, "settle_quiet", cyc - edge_t[$], SC);
                    end
                end
                edge_t.delete();
            end
            prev_done = done;
        end
    end

    // Loads a seed, issues one request and pushes the predicted outcome.
    task automatic issue(input bit tgt, input logic [15:0] s, input bit push);
        logic [15:0] q;
        int p, t, n, g;
        @(negedge clk);
        seed = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        seed = 16'($urandom);
        start = 1'b1;
        target = tgt;
        p = cyc + 1;
        if (push) begin
            q = (s == 16'd0) ? 16'hACE1 : s;
            if (tgt == cur_sig) begin
                exp_done_q.push_back(p);
                exp_tgt_q.push_back(tgt);
                exp_edges_q.push_back(0);
            end else begin
                n = bounces(q);
                t = p;
                for (int i = 0; i < 2 * n; i++) begin
                    g = MG + (int'(q[15:4]) & GM);
                    t += g + 1;
                    exp_sp_q.push_back(g + 1);
                    for (int k = 0; k <= g; k++) q = step(q);
                end
                exp_done_q.push_back(t + SC);
                exp_tgt_q.push_back(tgt);
                exp_edges_q.push_back(2 * n + 1);
            end
        end
        cur_sig = tgt;
        @(negedge clk);
        start = 1'b0;
        target = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (!ready && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(ready === 1'b1, "idle_timeout", i, budget);
    endtask

    initial begin
        logic [15:0] s;
        int cnt;
        logic pv;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(sig === 1'b0, "reset_sig", int'(sig), 0);
        chk(ready === 1'b1, "reset_ready", int'(ready), 1);
        chk(busy === 1'b0, "reset_busy", int'(busy), 0);
        chk(done === 1'b0, "reset_done", int'(done), 0);

        // Request for the level already present: immediate done, no edges.
        issue(1'b0, 16'($urandom), 1'b1);
        wait_idle(200);

        // Zero-bounce: seed picked so the pair count is zero.
        s = 16'($urandom);
        while (s == 16'd0 || bounces(s) != 0) s = 16'($urandom);
        issue(1'b1, s, 1'b1);
        wait_idle(200);
        chk(sig === 1'b1, "zero_bounce_sig", int'(sig), 1);

        for (int i = 0; i < 200; i++) begin
            s = (i == 0) ? 16'd0 : 16'($urandom);
            issue(i[0], s, 1'b1);
            wait_idle(200);
        end

        // A start and seed load while busy must not disturb the running transaction.
        issue(1'b0, 16'($urandom), 1'b1);
        wait_idle(200);
        s = 16'($urandom);
        while (s == 16'd0 || bounces(s) == 0) s = 16'($urandom);
        issue(1'b1, s, 1'b1);
        repeat (2) @(negedge clk);
        chk(busy === 1'b1, "busy_window", int'(busy), 1);
        start = 1'b1;
        target = 1'b0;
        seed_load = 1'b1;
        seed = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        seed_load = 1'b0;
        wait_idle(200);
        chk(sig === 1'b1, "busy_ignore_sig", int'(sig), 1);

        // Reset asserted in GAP right after the second edge.
        s = 16'($urandom);
        while (s == 16'd0 || bounces(s) == 0) s = 16'($urandom);
        issue(~cur_sig, s, 1'b0);
        cnt = 1;
        pv = sig;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(negedge clk);
            if (sig !== pv) cnt++;
            pv = sig;
        end
        chk(cnt == 2, "second_edge", cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk(sig === 1'b0, "midreset_sig", int'(sig), 0);
        chk(ready === 1'b1, "midreset_ready", int'(ready), 1);
        chk(busy === 1'b0, "midreset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur_sig = 1'b0;
        issue(1'b1, 16'($urandom), 1'b1);
        wait_idle(200);
        chk(sig === 1'b1, "post_reset_sig", int'(sig), 1);

        repeat (2) @(negedge clk);
        chk(exp_done_q.size() == 0, "pending_expectations", exp_done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 The parameter list SHALL be exactly as follows, one per line: name, default, meaning.
- INIT_LEVEL, 1'b0, sig level after reset.
- MIN_GAP, 50_000, minimum cycles between bounce edges (1 ms at 50 MHz).
- GAP_MASK, 18'h3FFFF, mask on the random extra gap.
- BOUNCE_MASK, 4'hF, mask on the random bounce-pair count n.
- SETTLE_CYCLES, 5_000_000, stable hold time after the last edge (100 ms).
REQ-002 The ports SHALL be exactly as follows, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- start, in, 1, single-cycle request, sampled only in IDLE.
- target, in, 1, requested final level, sampled with start.
- seed_load, in, 1, load seed into the LFSR, honoured only in IDLE.
- seed, in, 16, LFSR seed.
- sig, out, 1, registered noisy button emulation.
- ready, out, 1, high in IDLE.
- busy, out, 1, high in GAP and SETTLE.
- done, out, 1, one-cycle pulse at transaction end.

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, GAP, SETTLE and DONE, with ready=1 only in IDLE, busy=1 only in GAP or SETTLE, and done=1 only in DONE.
REQ-004 A 16-bit Galois LFSR SHALL advance every clock using polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
- Reset value: 16'hACE1.
- seed_load in IDLE loads seed; a seed of 0 is replaced by 16'hACE1.
- seed_load outside IDLE is ignored.
REQ-005 IDLE with start=1 and target==sig SHALL go to DONE, leaving sig unchanged.
REQ-006 IDLE with start=1 and target!=sig SHALL, at that edge, do all of the following:
- toggle sig;
- latch n = lfsr[3:0] & BOUNCE_MASK and set remaining = 2n;
- load gap_cnt = MIN_GAP + (lfsr[15:4] & GAP_MASK);
- go to GAP if n>0, otherwise go to SETTLE.
REQ-007 In GAP, gap_cnt SHALL decrement each cycle. At gap_cnt==0:
- toggle sig and decrement remaining;
- reload gap_cnt from the current LFSR;
- go to SETTLE when remaining was 1.
REQ-008 Consecutive sig edges SHALL therefore be spaced MIN_GAP+r+1 cycles apart, with 0 <= r <= GAP_MASK.
REQ-009 Each transaction SHALL produce 2n+1 edges, always an odd count no greater than 2*BOUNCE_MASK+1, with final sig equal to target.
REQ-010 SETTLE SHALL be entered with settle_cnt = SETTLE_CYCLES-1, hold sig constant, decrement settle_cnt, and at 0 go to DONE.
REQ-011 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-012 start while not in IDLE SHALL be ignored, with no queuing; target and seed changes mid-transaction SHALL have no effect.
REQ-013 The gap counter SHALL be sized for MIN_GAP+GAP_MASK (19 bits at defaults). The settle counter SHALL be sized for SETTLE_CYCLES (23 bits at defaults). Additions SHALL not wrap.

Reset
REQ-014 Asserting rst_n low at any time, including mid-bounce, SHALL immediately force the following:
- state=IDLE;
- sig=INIT_LEVEL;
- lfsr=16'hACE1;
- gap_cnt, settle_cnt and remaining = 0;
- ready=1, busy=0, done=0.
REQ-015 After deassertion, the first start SHALL be honoured on the first clock edge.

Structure
REQ-016 A shared package SHALL hold the state encoding (2-bit: IDLE=0, GAP=1, SETTLE=2, DONE=3), LFSR_RESET=16'hACE1 and LFSR_POLY=16'hB400.
REQ-017 The LFSR SHALL be one sub-module, lfsr16, with ports clk, rst_n, load, seed and q. bounce_gen SHALL contain only the FSM and counters.

Verification
Bench overrides: MIN_GAP=4, GAP_MASK=3, BOUNCE_MASK=3, SETTLE_CYCLES=10.
REQ-018 Reset check: after reset, sig=0, ready=1, busy=0, done=0.
- Pulse start with target=0 -> done high exactly 1 cycle later, with zero edges on sig.
REQ-019 Zero-bounce check: seed_load with a seed chosen by the reference model to give n=0, then start with target=1.
- sig rises on the start edge, with exactly 1 edge.
- done asserts 11 cycles later.
REQ-020 Random check: 200 transactions with random seeds and alternating targets. Per transaction, the scoreboard requires all of the following:
- an odd edge count, no greater than 7;
- every edge spacing in [5,8];
- final sig equal to target;
- no edge during the 10 SETTLE cycles;
- exactly one done pulse.
REQ-021 Busy-ignore check: issue start with target=0 while busy during a target=1 transaction -> the transaction is unaffected and ends with sig=1.
REQ-022 Mid-bounce reset check: assert rst_n low during GAP after the 2nd edge -> sig=0 within the same cycle, and ready=1.
- After release, a new start with target=1 completes normally.
